// File: rtl/io_in_pkg.sv
// Shared sizing constants for the I/O input conditioning stage.
// Build with IO_IN_DEBOUNCE_EN defined to enable the stability counters.
package io_in_pkg;
    localparam int PORT_W         = 4;
    localparam int NUM_PORTS      = 2;
    localparam int DEF_STABLE_CNT = 50000;

    typedef logic [PORT_W-1:0] port_t;
endpackage

// File: rtl/io_in_filter_bit.sv
// io_bit_debounce: one input bit -- two-flop synchronizer plus stability filter.
// IO_IN_DEBOUNCE_EN selects counter-based filtering; otherwise d follows s2 directly.
module io_bit_debounce
    import io_in_pkg::*;
#(
    parameter int STABLE_CNT = DEF_STABLE_CNT
) (
    input  logic clock,
    input  logic resetn,
    input  logic raw,
    output logic filt,
    output logic changed
);
    logic s1, s2, d;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

`ifdef IO_IN_DEBOUNCE_EN
    localparam int CW = $clog2(STABLE_CNT + 1);
    localparam logic [CW-1:0] C_LAST = CW'(STABLE_CNT - 1);

    logic [CW-1:0] c;
    logic          upd;

    // changed is the update condition itself, so the sticky flag lands on the same edge as d
    assign upd     = (s2 != d) && (c == C_LAST);
    assign changed = upd;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            d <= 1'b0;
            c <= '0;
        end else if (s2 == d) begin
            c <= '0;
        end else if (c == C_LAST) begin
            d <= s2;
            c <= '0;
        end else begin
            c <= c + CW'(1);
        end
    end
`else
    assign changed = (s2 != d);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) d <= 1'b0;
        else         d <= s2;
    end
`endif

    assign filt = d;
endmodule

// File: rtl/io_in_filter.sv
// io_in_filter: synchronizes and debounces two 4-bit switch ports feeding the memory stage.
// Debounce counters exist only when IO_IN_DEBOUNCE_EN is defined.
module io_in_filter
    import io_in_pkg::*;
#(
    parameter int STABLE_CNT = DEF_STABLE_CNT
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic [PORT_W-1:0]    raw_port1,
    input  logic [PORT_W-1:0]    raw_port2,
    input  logic [NUM_PORTS-1:0] chg_clr,
    output logic [PORT_W-1:0]    input_port1,
    output logic [PORT_W-1:0]    input_port2,
    output logic [NUM_PORTS-1:0] chg
);
    logic [NUM_PORTS-1:0][PORT_W-1:0] raw, filt, changed;
    logic [NUM_PORTS-1:0]             chg_set;

    assign raw = {raw_port2, raw_port1};

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        for (genvar b = 0; b < PORT_W; b++) begin : g_bit
            io_bit_debounce #(.STABLE_CNT(STABLE_CNT)) u_bit (
                .clock   (clock),
                .resetn  (resetn),
                .raw     (raw[p][b]),
                .filt    (filt[p][b]),
                .changed (changed[p][b])
            );
        end
        assign chg_set[p] = |changed[p];
    end

    // set wins over a coincident clear
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) chg <= '0;
        else         chg <= chg_set | (chg & ~chg_clr);
    end

    assign input_port1 = filt[0];
    assign input_port2 = filt[1];
endmodule

// File: tb/tb_io_in_filter.sv
// Directed self-checking bench for io_in_filter with STABLE_CNT=4.
// Exercises the debounce path when IO_IN_DEBOUNCE_EN is defined, the pass-through path otherwise.
module tb_io_in_filter;
    logic       clock = 1'b0;
    logic       resetn;
    logic [3:0] raw_port1, raw_port2;
    logic [1:0] chg_clr;
    logic [3:0] input_port1, input_port2;
    logic [1:0] chg;

    int checks = 0;
    int errors = 0;

    io_in_filter #(.STABLE_CNT(4)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .raw_port1   (raw_port1),
        .raw_port2   (raw_port2),
        .chg_clr     (chg_clr),
        .input_port1 (input_port1),
        .input_port2 (input_port2),
        .chg         (chg)
    );

    always #5 clock = ~clock;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        resetn    = 1'b0;
        raw_port1 = 4'hA;
        raw_port2 = 4'h0;
        chg_clr   = 2'b00;
        step(3);
        check("rst_p1", 8'(input_port1), 8'h0);
        check("rst_p2", 8'(input_port2), 8'h0);
        check("rst_chg", 8'(chg), 8'h0);
        resetn = 1'b1;

`ifdef IO_IN_DEBOUNCE_EN
        // reset release with high inputs: edges 0..4 hold, edge 5 updates
        step(5);
        check("rel_p1_hold", 8'(input_port1), 8'h0);
        check("rel_chg_hold", 8'(chg), 8'h0);
        step(1);
        check("rel_p1_upd", 8'(input_port1), 8'hA);
        check("rel_chg_upd", 8'(chg), 8'h1);
        chg_clr = 2'b01;
        step(1);
        chg_clr = 2'b00;
        check("clr0", 8'(chg), 8'h0);

        // 3-cycle glitch on port 2 bit 0 is rejected
        raw_port2 = 4'h1;
        step(3);
        raw_port2 = 4'h0;
        step(6);
        check("glitch_p2", 8'(input_port2), 8'h0);
        check("glitch_chg", 8'(chg), 8'h0);

        // stable change on port 2, then clear
        raw_port2 = 4'h5;
        step(5);
        check("p2_hold", 8'(input_port2), 8'h0);
        step(1);
        check("p2_upd", 8'(input_port2), 8'h5);
        check("p2_chg", 8'(chg), 8'h2);
        chg_clr = 2'b10;
        step(1);
        chg_clr = 2'b00;
        check("clr1", 8'(chg), 8'h0);
        check("p2_keep", 8'(input_port2), 8'h5);

        // clear coincident with port 1 update: set wins
        raw_port1 = 4'h3;
        step(5);
        check("p1_hold", 8'(input_port1), 8'hA);
        check("p1_chg_hold", 8'(chg), 8'h0);
        chg_clr = 2'b01;
        step(1);
        chg_clr = 2'b00;
        check("sim_p1", 8'(input_port1), 8'h3);
        check("sim_chg", 8'(chg), 8'h1);
        chg_clr = 2'b10;
        step(1);
        chg_clr = 2'b00;
        check("noop_clr", 8'(chg), 8'h1);

        // reset mid-count (c=2 after four edges) discards progress
        raw_port1 = 4'hF;
        step(4);
        resetn = 1'b0;
        #1;
        check("async_p1", 8'(input_port1), 8'h0);
        check("async_p2", 8'(input_port2), 8'h0);
        check("async_chg", 8'(chg), 8'h0);
        step(2);
        resetn = 1'b1;
        step(5);
        check("re_p1_hold", 8'(input_port1), 8'h0);
        step(1);
        check("re_p1_upd", 8'(input_port1), 8'hF);
        check("re_p2_upd", 8'(input_port2), 8'h5);
        check("re_chg_both", 8'(chg), 8'h3);
`else
        // pass-through: output follows two edges after sampling
        step(2);
        check("rel_p1_hold", 8'(input_port1), 8'h0);
        step(1);
        check("rel_p1_upd", 8'(input_port1), 8'hA);
        check("rel_chg_upd", 8'(chg), 8'h1);
        raw_port1 = 4'h0;
        step(3);
        chg_clr = 2'b01;
        step(1);
        chg_clr = 2'b00;
        check("settle_p1", 8'(input_port1), 8'h0);
        check("clr0", 8'(chg), 8'h0);

        // single-cycle pulse passes through
        raw_port1 = 4'h8;
        step(1);
        raw_port1 = 4'h0;
        check("pulse_e0", 8'(input_port1), 8'h0);
        step(1);
        check("pulse_e1", 8'(input_port1), 8'h0);
        step(1);
        check("pulse_e2", 8'(input_port1), 8'h8);
        check("pulse_chg", 8'(chg), 8'h1);
        step(1);
        check("pulse_e3", 8'(input_port1), 8'h0);

        // port 2 change with coincident clear: set wins
        raw_port2 = 4'h5;
        step(2);
        chg_clr = 2'b10;
        step(1);
        chg_clr = 2'b00;
        check("p2_upd", 8'(input_port2), 8'h5);
        check("sim_chg", 8'(chg), 8'h3);
        chg_clr = 2'b11;
        step(1);
        chg_clr = 2'b00;
        check("clr_both", 8'(chg), 8'h0);

        resetn = 1'b0;
        #1;
        check("async_p2", 8'(input_port2), 8'h0);
        check("async_chg", 8'(chg), 8'h0);
        resetn = 1'b1;
        step(3);
        check("re_p2_upd", 8'(input_port2), 8'h5);
        check("re_chg", 8'(chg), 8'h2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
